// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - execute-stage to multiply/divide unit connection bundle
interface md_unit_if;
    logic [3:0]  XALUOp;
    logic [31:0] XALUa;
    logic [31:0] XALUb;
    logic        Start;
    logic        Busy;
    logic [31:0] XALU_Out;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side: drives opcode and operands, observes results
    modport master (
        output XALUOp,
        output XALUa,
        output XALUb,
        input  Start,
        input  Busy,
        input  XALU_Out,
        input  HI,
        input  LO
    );

    // Unit side
    modport slave (
        input  XALUOp,
        input  XALUa,
        input  XALUb,
        output Start,
        output Busy,
        output XALU_Out,
        output HI,
        output LO
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle mult/div unit with private HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    md_unit_if.slave bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_skip;

    logic        is_mul;
    logic        is_div;
    logic        start;
    logic        busy;

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    logic [31:0] next_hi;
    logic [31:0] next_lo;

    assign busy   = (state == ST_RUN);
    assign is_mul = (bus.XALUOp == OP_MULT) || (bus.XALUOp == OP_MULTU);
    assign is_div = (bus.XALUOp == OP_DIV)  || (bus.XALUOp == OP_DIVU);
    assign start  = (is_mul || is_div) && !busy;

    // Full-width products; the sign-extended form yields the signed result in the low 64 bits
    assign prod_s = {{32{bus.XALUa[31]}}, bus.XALUa} * {{32{bus.XALUb[31]}}, bus.XALUb};
    assign prod_u = {32'd0, bus.XALUa} * {32'd0, bus.XALUb};

    // Sign-magnitude division so that 0x80000000 / -1 wraps to 0x80000000 instead of trapping
    always_comb begin
        div_signed = (bus.XALUOp == OP_DIV);
        a_neg      = div_signed && bus.XALUa[31];
        b_neg      = div_signed && bus.XALUb[31];
        a_mag      = a_neg ? (32'd0 - bus.XALUa) : bus.XALUa;
        b_mag      = b_neg ? (32'd0 - bus.XALUb) : bus.XALUb;
        div_zero   = (bus.XALUb == 32'd0);
        q_mag      = 32'd0;
        r_mag      = 32'd0;
        if (!div_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Select the pending result to latch at start
    always_comb begin
        next_hi = 32'd0;
        next_lo = 32'd0;
        case (bus.XALUOp)
            OP_MULT: begin
                next_hi = prod_s[63:32];
                next_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                next_hi = prod_u[63:32];
                next_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                next_hi = rem;
                next_lo = quot;
            end
            default: begin
                next_hi = 32'd0;
                next_lo = 32'd0;
            end
        endcase
    end

    // Control FSM: start latches pending results, the last RUN cycle commits them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
            p_skip <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        p_hi   <= next_hi;
                        p_lo   <= next_lo;
                        p_skip <= is_div && div_zero;
                        cnt    <= is_mul ? MULT_LOAD : DIV_LOAD;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Committed HI/LO: written by an ending operation or by mthi/mtlo while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (busy) begin
            if ((cnt == 4'd1) && !p_skip) begin
                hi_q <= p_hi;
                lo_q <= p_lo;
            end
        end else if (bus.XALUOp == OP_MTHI) begin
            hi_q <= bus.XALUa;
        end else if (bus.XALUOp == OP_MTLO) begin
            lo_q <= bus.XALUa;
        end
    end

    // Read-out path to the ALU-a operand mux
    always_comb begin
        bus.XALU_Out = 32'd0;
        if (bus.XALUOp == OP_MFHI) begin
            bus.XALU_Out = hi_q;
        end else if (bus.XALUOp == OP_MFLO) begin
            bus.XALU_Out = lo_q;
        end
    end

    assign bus.Start = start;
    assign bus.Busy  = busy;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
module tb_md_unit;

    logic clk;
    logic reset;

    md_unit_if bus ();

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } commit_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } read_t;

    commit_t commit_q[$];
    read_t   read_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations when the unit finishes an operation or serves a read
    int busy_cnt  = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        commit_t c;
        read_t   r;
        if (reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (bus.XALUOp == 4'd7 || bus.XALUOp == 4'd8) begin
                if (read_q.size() == 0) begin
                    check("read_unexpected", 32'd1, 32'd0);
                end else begin
                    r = read_q.pop_front();
                    check({r.name, "_out"}, bus.XALU_Out, r.val);
                end
            end
            if (bus.Busy) busy_cnt++;
            if (prev_busy && !bus.Busy) begin
                if (commit_q.size() == 0) begin
                    check("commit_unexpected", 32'd1, 32'd0);
                end else begin
                    c = commit_q.pop_front();
                    check({c.name, "_busy_cycles"}, 32'(busy_cnt), 32'(c.cycles));
                    check({c.name, "_hi"}, bus.HI, c.hi);
                    check({c.name, "_lo"}, bus.LO, c.lo);
                end
                busy_cnt = 0;
            end
            prev_busy = bus.Busy;
        end
    end

    // Drive one op for exactly one edge; call at posedge+1, returns at next posedge+1
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start, input string name);
        bus.XALUOp = op;
        bus.XALUa  = a;
        bus.XALUb  = b;
        #1;
        check({name, "_start"}, {31'd0, bus.Start}, {31'd0, exp_start});
        @(posedge clk);
        #1;
        bus.XALUOp = 4'd0;
        bus.XALUa  = 32'd0;
        bus.XALUb  = 32'd0;
    endtask

    task automatic expect_commit(input string name, input int cycles,
                                 input logic [31:0] hi, input logic [31:0] lo);
        commit_t c;
        c.name = name; c.cycles = cycles; c.hi = hi; c.lo = lo;
        commit_q.push_back(c);
    endtask

    task automatic expect_read(input string name, input logic [31:0] val);
        read_t r;
        r.name = name; r.val = val;
        read_q.push_back(r);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.Busy) done = 1'b1;
        end
        if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.XALUOp = 4'd0;
        bus.XALUa  = 32'd0;
        bus.XALUb  = 32'd0;
        reset      = 1'b0;
        #1 reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, bus.Busy},  32'd0);
        check("rst_start", {31'd0, bus.Start}, 32'd0);
        check("rst_hi",    bus.HI,       32'd0);
        check("rst_lo",    bus.LO,       32'd0);
        check("rst_out",   bus.XALU_Out, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a divide discards it
        issue(4'd5, 32'h55, 32'd0, 1'b0, "pre_mthi");
        issue(4'd6, 32'h66, 32'd0, 1'b0, "pre_mtlo");
        issue(4'd3, 32'd100, 32'd7, 1'b1, "div_rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        check("midrst_hi",   bus.HI, 32'd0);
        check("midrst_lo",   bus.LO, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_nocommit_hi", bus.HI, 32'd0);
        check("midrst_nocommit_lo", bus.LO, 32'd0);

        // Multiply, signed and unsigned
        expect_commit("mult_neg2x3", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        issue(4'd1, 32'hFFFFFFFE, 32'h3, 1'b1, "mult_neg2x3");
        wait_idle("mult_neg2x3");
        expect_commit("multu_neg2x3", 5, 32'h00000002, 32'hFFFFFFFA);
        issue(4'd2, 32'hFFFFFFFE, 32'h3, 1'b1, "multu_neg2x3");
        wait_idle("multu_neg2x3");
        expect_commit("mult_m1xm1", 5, 32'h0, 32'h1);
        issue(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "mult_m1xm1");
        wait_idle("mult_m1xm1");
        expect_commit("multu_maxmax", 5, 32'hFFFFFFFE, 32'h00000001);
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "multu_maxmax");
        wait_idle("multu_maxmax");

        // Divide, signed truncation and unsigned, plus the overflow corner
        expect_commit("div_m7_2", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, "div_m7_2");
        wait_idle("div_m7_2");
        expect_commit("divu_7_2", 10, 32'd1, 32'd3);
        issue(4'd4, 32'd7, 32'd2, 1'b1, "divu_7_2");
        wait_idle("divu_7_2");
        expect_commit("div_7_m2", 10, 32'd1, 32'hFFFFFFFD);
        issue(4'd3, 32'd7, 32'hFFFFFFFE, 1'b1, "div_7_m2");
        wait_idle("div_7_m2");
        expect_commit("div_ovf", 10, 32'h0, 32'h80000000);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");
        wait_idle("div_ovf");

        // mthi/mtlo then immediate reads
        issue(4'd5, 32'h12345678, 32'd0, 1'b0, "mthi");
        issue(4'd6, 32'h9ABCDEF0, 32'd0, 1'b0, "mtlo");
        expect_read("mfhi", 32'h12345678);
        issue(4'd7, 32'd0, 32'd0, 1'b0, "mfhi");
        expect_read("mflo", 32'h9ABCDEF0);
        issue(4'd8, 32'd0, 32'd0, 1'b0, "mflo");

        // Divide by zero leaves HI/LO untouched
        issue(4'd5, 32'h11, 32'd0, 1'b0, "mthi_11");
        issue(4'd6, 32'h22, 32'd0, 1'b0, "mtlo_22");
        expect_commit("divu_by0", 10, 32'h11, 32'h22);
        issue(4'd4, 32'd5, 32'd0, 1'b1, "divu_by0");
        wait_idle("divu_by0");
        expect_commit("div_by0", 10, 32'h11, 32'h22);
        issue(4'd3, 32'hFFFFFFF0, 32'd0, 1'b1, "div_by0");
        wait_idle("div_by0");

        // Ops during Busy are ignored; reads see committed values only
        expect_commit("mult_6x7", 5, 32'h0, 32'd42);
        issue(4'd1, 32'd6, 32'd7, 1'b1, "mult_6x7");
        issue(4'd5, 32'hDEAD, 32'd0, 1'b0, "busy_mthi");
        issue(4'd1, 32'd3, 32'd3, 1'b0, "busy_mult");
        expect_read("busy_mflo", 32'h22);
        issue(4'd8, 32'd0, 32'd0, 1'b0, "busy_mflo");
        expect_read("busy_mfhi", 32'h11);
        issue(4'd7, 32'd0, 32'd0, 1'b0, "busy_mfhi");
        wait_idle("mult_6x7");
        expect_read("post_mfhi", 32'h0);
        issue(4'd7, 32'd0, 32'd0, 1'b0, "post_mfhi");
        expect_read("post_mflo", 32'd42);
        issue(4'd8, 32'd0, 32'd0, 1'b0, "post_mflo");

        repeat (3) @(posedge clk);
        #1;
        check("commit_q_drained", 32'(commit_q.size()), 32'd0);
        check("read_q_drained",   32'(read_q.size()),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the execute stage of the five-stage MIPS pipeline. It consumes the forwarded RS/RT operands and the XALU opcode of the instruction in E. It runs mult/multu/div/divu over several cycles into private HI/LO registers and supplies mfhi/mflo data to the ALU-a operand mux. Its busy output feeds the stall unit, which holds any HI/LO-touching instruction in D while an operation is in flight.

## Interface
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu start (≥1)
- DIV_CYCLES, 10, cycles busy stays high after a div/divu start (≥1)
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- XALUOp  input  4  opcode of instruction in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 none
- XALUa  input  32  forwarded RS value in E
- XALUb  input  32  forwarded RT value in E
- Start  output  1  combinational: XALUOp ∈ {1,2,3,4} and !Busy
- Busy  output  1  registered: operation in flight
- XALU_Out  output  32  combinational: HI when XALUOp=7, LO when 8, else 0
- HI  output  32  committed HI register
- LO  output  32  committed LO register

## Operation
- States: IDLE (Busy=0), RUN (Busy=1). Down-counter cnt, 4 bits, is active only in RUN.
- IDLE, Start at edge:
  - latch pending results, {pHI,pLO}:
    - mult: signed 64-bit product of XALUa×XALUb
    - multu: unsigned product
    - div: pLO = signed quotient (truncate toward zero), pHI = signed remainder (sign of dividend)
    - divu: unsigned quotient/remainder
  - cnt ← MULT_CYCLES or DIV_CYCLES; go to RUN.
- Divide by zero (XALUb=0, div/divu): accepted, runs full DIV_CYCLES, then HI/LO are left unchanged (no commit).
- Signed overflow case div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- RUN, each edge: cnt ← cnt−1. On the edge where cnt==1: HI←pHI, LO←pLO (unless div-by-zero), go to IDLE.
- mthi/mtlo in IDLE: HI←XALUa or LO←XALUa at the edge.
- Any XALUOp received while Busy=1 is ignored: no start, no write, and XALU_Out still reads the committed HI/LO. The stall unit guarantees this does not occur in legal flow.
- mfhi/mflo read committed HI/LO only. Pending results are never visible before commit.
- Reset (any time, including mid-RUN): HI=0, LO=0, pHI=pLO=0, cnt=0, Busy=0, state IDLE. The in-flight operation is discarded.

## Timing
- Reset values: Busy=0, HI=0, LO=0, Start=0 and XALU_Out=0 while XALUOp=0.
- Start is sampled at edge E0. Busy is high for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES). The commit happens on edge E0+N, and Busy is 0 in the same cycle the new HI/LO first appear.
- The stall unit uses Start|Busy, so the instruction directly behind a mult/div never sees stale HI/LO.
- A new start is accepted on edge E0+N+1 at the earliest: back-to-back ops incur no extra bubble beyond N.
- mthi/mtlo: write visible the cycle after the edge (zero latency to a following mfhi via the register).
- XALU_Out: purely combinational from XALUOp, HI and LO, with no registered delay.

## Test plan
- Reset mid-RUN: start div, assert reset at cycle 3 → Busy=0, HI=LO=0 immediately. No commit occurs afterwards.
- mult 0xFFFFFFFE × 0x00000003 → Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div −7 / 2 → after 10 cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu 7/2 → LO=3, HI=1.
- mthi 0x12345678 then mtlo 0x9ABCDEF0, then mfhi/mflo → XALU_Out 0x12345678 / 0x9ABCDEF0.
- div by zero with HI=0x11, LO=0x22 preloaded → Busy 10 cycles, HI/LO still 0x11/0x22.
- During Busy, apply mthi 0xDEAD and mult → no state change. mflo during Busy returns the old LO. The pending result commits at the correct cycle.
